// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
package servo_pkg;

  localparam int unsigned US_W = 12;

  typedef logic [US_W-1:0] us_t;

  function automatic int unsigned period_clks(input longint unsigned clk_hz,
                                              input longint unsigned period_ms);
    return 32'(clk_hz * period_ms / 64'd1000);
  endfunction

  function automatic int unsigned clks_per_us(input int unsigned clk_hz);
    return clk_hz / 32'd1_000_000;
  endfunction

  function automatic int unsigned ch_width(input int unsigned n_ch);
    return (n_ch <= 1) ? 32'd1 : 32'($clog2(n_ch));
  endfunction

  function automatic us_t clamp_us(input us_t v, input us_t lo, input us_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Write port and per-channel servo outputs between the race-control FSM and the PWM block.
interface servo_pwm_multi_if #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
);
  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [11:0]     wr_pulse_us;
  logic [N_CH-1:0] ch_enable;
  logic [N_CH-1:0] servo_pwm_out;
  logic            frame_start;
  logic [N_CH-1:0] at_target;

  modport master (
    output wr_en, wr_ch, wr_pulse_us, ch_enable,
    input  servo_pwm_out, frame_start, at_target
  );

  modport slave (
    input  wr_en, wr_ch, wr_pulse_us, ch_enable,
    output servo_pwm_out, frame_start, at_target
  );
endinterface

// File: rtl/servo_pwm_ch.sv
// One servo channel: target/current width, per-frame slew, compare register and output flop.
module servo_pwm_ch
  import servo_pkg::*;
#(
  parameter int unsigned CMP_W       = 19,
  parameter int unsigned CLKS_PER_US = 25,
  parameter int unsigned DEFAULT_US  = 1000,
  parameter int unsigned STEP_US     = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boundary,
  input  logic [CMP_W-1:0] cnt,
  input  logic             wr,
  input  us_t              wr_val,
  input  logic             en,
  output logic             pwm,
  output logic             at_target
);

  localparam us_t STEP    = US_W'(STEP_US);
  localparam us_t DEFAULT = US_W'(DEFAULT_US);

  us_t              target, cur, cur_next, target_next;
  logic [CMP_W-1:0] width_q;
  logic             en_q;

  // Slew reads the pre-edge target, so a write landing on the boundary waits one frame.
  always_comb begin
    cur_next    = cur;
    target_next = wr ? wr_val : target;
    if (boundary) begin
      if (STEP_US == 0) begin
        cur_next = target;
      end else if (target > cur) begin
        cur_next = (target - cur > STEP) ? cur + STEP : target;
      end else if (target < cur) begin
        cur_next = (cur - target > STEP) ? cur - STEP : target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target    <= DEFAULT;
      cur       <= DEFAULT;
      width_q   <= CMP_W'(DEFAULT_US * CLKS_PER_US);
      en_q      <= 1'b0;
      pwm       <= 1'b0;
      at_target <= 1'b1;
    end else begin
      target    <= target_next;
      cur       <= cur_next;
      if (boundary) begin
        width_q <= CMP_W'(cur_next) * CMP_W'(CLKS_PER_US);
        en_q    <= en;
      end
      pwm       <= en_q && (cnt < width_q);
      at_target <= (cur_next == target_next);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// N_CH hobby-servo PWM outputs sharing one frame counter; widths written in microseconds.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 25_000_000,
  parameter int unsigned SERVO_PERIOD_MS = 20,
  parameter int unsigned N_CH            = 4,
  parameter int unsigned MIN_US          = 1000,
  parameter int unsigned MAX_US          = 2000,
  parameter int unsigned DEFAULT_US      = 1000,
  parameter int unsigned STEP_US         = 100
) (
  input  logic            clk,
  input  logic            reset,
  servo_pwm_multi_if.slave bus
);

  localparam int unsigned PERIOD_CLKS = period_clks(CLK_FREQ_HZ, SERVO_PERIOD_MS);
  localparam int unsigned CLKS_PER_US = clks_per_us(CLK_FREQ_HZ);
  localparam int unsigned CMP_W       = $clog2(PERIOD_CLKS);
  localparam int unsigned CH_W        = ch_width(N_CH);

  logic [CMP_W-1:0] cnt;
  logic             boundary;
  logic             frame_start_q;
  logic             wr_valid;
  us_t              wr_val;
  logic [N_CH-1:0]  pwm;
  logic [N_CH-1:0]  at_tgt;

  assign boundary = (cnt == CMP_W'(PERIOD_CLKS - 1));
  assign wr_valid = bus.wr_en && (32'(bus.wr_ch) < N_CH);
  assign wr_val   = clamp_us(bus.wr_pulse_us, US_W'(MIN_US), US_W'(MAX_US));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      cnt           <= boundary ? '0 : cnt + 1'b1;
      frame_start_q <= (cnt == '0);
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_ch #(
      .CMP_W      (CMP_W),
      .CLKS_PER_US(CLKS_PER_US),
      .DEFAULT_US (DEFAULT_US),
      .STEP_US    (STEP_US)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .boundary (boundary),
      .cnt      (cnt),
      .wr       (wr_valid && (bus.wr_ch == CH_W'(i))),
      .wr_val   (wr_val),
      .en       (bus.ch_enable[i]),
      .pwm      (pwm[i]),
      .at_target(at_tgt[i])
    );
  end

  assign bus.servo_pwm_out = pwm;
  assign bus.at_target     = at_tgt;
  assign bus.frame_start   = frame_start_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench: dut_a (3 ch, slewed) and dut_b (4 ch, no slew) at 2 clks/us, 6000-clk frames.
module tb_servo_pwm_multi;

  localparam int P = 6000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  servo_pwm_multi_if #(.N_CH(3), .CH_W(2)) bus_a ();
  servo_pwm_multi_if #(.N_CH(4), .CH_W(2)) bus_b ();

  servo_pwm_multi #(
    .CLK_FREQ_HZ(2_000_000), .SERVO_PERIOD_MS(3), .N_CH(3),
    .MIN_US(1000), .MAX_US(2000), .DEFAULT_US(1000), .STEP_US(100)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  servo_pwm_multi #(
    .CLK_FREQ_HZ(2_000_000), .SERVO_PERIOD_MS(3), .N_CH(4),
    .MIN_US(1000), .MAX_US(2000), .DEFAULT_US(1000), .STEP_US(0)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_errors = 0;

  // High-cycle counts per frame; row 6 is the frame cut short by reset.
  int exp_a [0:8][0:2] = '{
    '{0, 0, 0}, '{2200, 2000, 2000}, '{2400, 2000, 2000}, '{2600, 2000, 2000},
    '{2800, 2000, 2000}, '{3000, 2000, 2000}, '{0, 0, 0}, '{0, 0, 0}, '{2000, 2000, 2000}
  };
  int exp_b [0:8][0:3] = '{
    '{0, 0, 0, 0}, '{2000, 3000, 2000, 2400}, '{2000, 3000, 4000, 2000},
    '{2000, 0, 4000, 2000}, '{4000, 0, 4000, 2000}, '{4000, 0, 4000, 2000},
    '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{2000, 2000, 2000, 2000}
  };
  logic [2:0] at_a [0:8] = '{3'b111, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b111};
  logic [3:0] at_b [0:8] = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr_a(input int ch, input int us);
    bus_a.wr_en = 1'b1; bus_a.wr_ch = 2'(ch); bus_a.wr_pulse_us = 12'(us);
  endtask

  task automatic wr_b(input int ch, input int us);
    bus_b.wr_en = 1'b1; bus_b.wr_ch = 2'(ch); bus_b.wr_pulse_us = 12'(us);
  endtask

  // Driven right after the sample of window cycle j, so it lands on the edge ending cycle j.
  task automatic apply(input int f, input int j);
    bus_a.wr_en = 1'b0;
    bus_b.wr_en = 1'b0;
    case (f)
      0: begin
        if (j == 100) begin wr_a(0, 1500); wr_b(1, 1500); end
        if (j == 101) wr_b(3, 1200);
        if (j == 102) begin
          check("at_a_after_wr", 32'(bus_a.at_target), 32'(3'b110));
          check("at_b_after_wr", 32'(bus_b.at_target), 32'(4'b0101));
        end
      end
      1: begin
        if (j == 100) wr_b(2, 3000);
        if (j == 101) wr_b(3, 500);
      end
      2: begin
        if (j == 200) wr_a(3, 2000);
        if (j == 3000) bus_b.ch_enable = 4'b1101;
        if (j == P - 2) wr_b(0, 2000);
      end
      5: if (j == 10) bus_b.ch_enable = 4'hF;
      default: ;
    endcase
  endtask

  task automatic wait_frame_start(input string tag);
    bit found = 1'b0;
    for (int w = 0; w < 2 * P && !found; w++) begin
      @(negedge clk);
      found = (bus_a.frame_start === 1'b1);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic measure(input int f);
    int ca [3];
    int cb [4];
    int fs_a = 0;
    int fs_b = 0;
    foreach (ca[c]) ca[c] = 0;
    foreach (cb[c]) cb[c] = 0;
    wait_frame_start($sformatf("fs_found_f%0d", f));
    check($sformatf("at_a_f%0d", f), 32'(bus_a.at_target), 32'(at_a[f]));
    check($sformatf("at_b_f%0d", f), 32'(bus_b.at_target), 32'(at_b[f]));
    for (int j = 0; j < P; j++) begin
      if (j > 0) @(negedge clk);
      for (int c = 0; c < 3; c++) ca[c] += int'(bus_a.servo_pwm_out[c]);
      for (int c = 0; c < 4; c++) cb[c] += int'(bus_b.servo_pwm_out[c]);
      fs_a += int'(bus_a.frame_start);
      fs_b += int'(bus_b.frame_start);
      apply(f, j);
    end
    for (int c = 0; c < 3; c++) check($sformatf("a_f%0d_ch%0d", f, c), 32'(ca[c]), 32'(exp_a[f][c]));
    for (int c = 0; c < 4; c++) check($sformatf("b_f%0d_ch%0d", f, c), 32'(cb[c]), 32'(exp_b[f][c]));
    check($sformatf("fs_a_cnt_f%0d", f), 32'(fs_a), 32'd1);
    check($sformatf("fs_b_cnt_f%0d", f), 32'(fs_b), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_ch = '0; bus_a.wr_pulse_us = '0; bus_a.ch_enable = 3'b111;
    bus_b.wr_en = 1'b0; bus_b.wr_ch = '0; bus_b.wr_pulse_us = '0; bus_b.ch_enable = 4'hF;
    repeat (4) @(negedge clk);
    check("rst_pwm_a", 32'(bus_a.servo_pwm_out), 32'd0);
    check("rst_pwm_b", 32'(bus_b.servo_pwm_out), 32'd0);
    check("rst_fs_a", 32'(bus_a.frame_start), 32'd0);
    check("rst_at_a", 32'(bus_a.at_target), 32'(3'b111));
    check("rst_at_b", 32'(bus_b.at_target), 32'(4'hF));
    reset = 1'b0;

    for (int f = 0; f < 6; f++) measure(f);

    wait_frame_start("fs_found_f6");
    repeat (500) @(negedge clk);
    check("pre_rst_pwm_a0", 32'(bus_a.servo_pwm_out[0]), 32'd1);
    check("pre_rst_pwm_b0", 32'(bus_b.servo_pwm_out[0]), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_pwm_a", 32'(bus_a.servo_pwm_out), 32'd0);
    check("midrst_pwm_b", 32'(bus_b.servo_pwm_out), 32'd0);
    check("midrst_fs_b", 32'(bus_b.frame_start), 32'd0);
    check("midrst_at_a", 32'(bus_a.at_target), 32'(3'b111));
    check("midrst_at_b", 32'(bus_b.at_target), 32'(4'hF));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    measure(7);
    measure(8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
Multi-channel successor to the single-flag servo driver. It generates N_CH independent 50 Hz hobby-servo PWM outputs from one shared frame counter. Each channel's pulse width is programmed in microseconds over a simple write port, clamped to a safe range, and slew-limited frame by frame so flags and barriers move smoothly. The block sits between the race-control FSM (the writer) and the servo output pins.

Parameters:
CLK_FREQ_HZ, 25_000_000, system clock frequency
SERVO_PERIOD_MS, 20, frame period; PERIOD_CLKS = CLK_FREQ_HZ*SERVO_PERIOD_MS/1000 (500_000)
N_CH, 4, number of servo channels (1..16)
MIN_US, 1000, lower clamp on pulse width
MAX_US, 2000, upper clamp on pulse width
DEFAULT_US, 1000, reset width for target and current (flag down)
STEP_US, 100, maximum change of applied width per frame; 0 = no slew (jump directly to target)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe, one cycle
wr_ch  in  CH_W=max(1,$clog2(N_CH))  channel index for the write
wr_pulse_us  in  12  requested pulse width in µs
ch_enable  in  N_CH  per-channel enable; sampled only at the frame boundary
servo_pwm_out  out  N_CH  PWM outputs, registered
frame_start  out  1  one-cycle pulse in cycle 0 of every frame
at_target  out  N_CH  high when the applied width equals the target width

Behaviour:
- Reset: cnt=0. target[i]=cur[i]=DEFAULT_US. enable_q=0. servo_pwm_out=0, frame_start=0, at_target=all 1. Reset asserted mid-frame aborts the frame immediately; outputs go low on the next edge.
- Frame counter: cnt runs 0..PERIOD_CLKS-1 and wraps. The first cycle after reset release is cnt=0. frame_start is registered and high exactly when the output-side cnt is 0.
- Write: if wr_en=1 and wr_ch<N_CH, then target[wr_ch] <= clamp(wr_pulse_us, MIN_US, MAX_US) on that edge. If wr_ch>=N_CH, the write is ignored. Multiple writes within a frame: the last one wins.
- Frame boundary (cycle with cnt=PERIOD_CLKS-1), for each channel:
  - cur moves toward target by min(|target-cur|, STEP_US). With STEP_US=0, cur=target.
  - width_clks[i] = cur_new*(CLK_FREQ_HZ/1_000_000), i.e. 25 clks/µs, computed combinationally into the compare register.
  - enable_q <= ch_enable.
- Write and boundary in the same cycle: the slew uses the target value held before that edge. The new target takes effect at the following boundary.
- Output: servo_pwm_out[i] is high for exactly width_clks[i] consecutive cycles starting in the frame_start cycle, when enable_q[i]=1. When enable_q[i]=0 it stays low for the whole frame. Width, enable and slew changes never apply mid-frame, so no truncated or stretched pulses.
- at_target[i] = (cur[i]==target[i]), registered. It drops the cycle after a write that differs from cur.
- Widths: cur/target are 12-bit unsigned. Compare register is $clog2(PERIOD_CLKS) bits (19). Clamp and slew comparisons are unsigned with no overflow (MAX_US+STEP_US < 4096).
- Latency: a write is visible on the output in the first frame following the next boundary (at most 1 frame + 1 cycle), then slews at STEP_US per frame.

Decomposition:
- Package servo_pkg: PERIOD_CLKS, CLKS_PER_US, CH_W derivation, and a clamp function.
- Sub-module servo_pwm_ch: holds target/cur registers, slew, the width_clks compare and the output flop for one channel. It is instantiated N_CH times in a generate loop.
- The top holds the shared counter, write decode and frame_start.

Test Plan:
- Reset, then idle with ch_enable=all 1 → every channel high 25_000 clks per 500_000-clk frame. frame_start period is 500_000 clks. at_target=all 1.
- STEP_US=0, write ch1=1500 → the next full frame on ch1 is 37_500 clks high. Other channels are unchanged.
- STEP_US=100, write ch0=1500 → successive frames are 27_500, 30_000, 32_500, 35_000, 37_500 clks. at_target[0] rises at the 5th boundary.
- Write 3000 to ch2, then 500 to ch3 → clamped to 50_000 and 25_000 clks. Write with wr_ch=N_CH → no change on any channel.
- Write at cnt=PERIOD_CLKS-1, and drop ch_enable[1] mid-frame → the write applies one boundary later. Ch1 finishes its current pulse and is low for the whole next frame.
- Assert reset at cnt=10_000 → all outputs are 0 next cycle. After release, the widths restart at 25_000 clks.
